rwc_chal_sched: RTL
===================

Name: rwc_chal_sched

Overview:
- Sequences a batch of challenges through the rwc_ctrl collision generator and builds a multi-bit PUF response from the results.
- Per challenge:
  - generates challenge data with an LFSR seeded by a parameter;
  - steps the address from a base value;
  - handshakes with rwc_ctrl via gen_enable/available;
  - reduces the captured rsp_write/rsp_clean pair to one response bit.
- Sits between the top-level FSM (start/done) and rwc_ctrl, replacing the single-shot IDLE/CREATE/DETECT sequencing.

Parameters:
- NUM_CHAL, 32, challenges per batch; legal range 1..32.
- SEED, 32'h2c77_d388, LFSR value loaded on start; a value of 0 is illegal.
- ADDR_STEP, 10'd1, address increment between challenges; modulo 1024.
- TIMEOUT_CYC, 4096, maximum cycles in WAIT_AVAIL before abort.
- GAP_CYC, 16, idle cycles between challenges; minimum 1.

Ports:
- clk  in  1  system clock (300 MHz domain).
- resetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to run a batch; ignored while busy.
- base_addr  in  10  first challenge address; sampled on an accepted start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the batch completes.
- response  out  32  response bits; bit i = challenge i; bits [31:NUM_CHAL] read 0.
- err_timeout  out  1  sticky; set if any challenge timed out; cleared on an accepted start.
- gen_enable  out  1  to rwc_ctrl.
- cha_data  out  32  to rwc_ctrl.
- cha_addr  out  32  to rwc_ctrl; upper 22 bits are 0.
- available  in  1  from rwc_ctrl.
- rsp_write  in  32  from rwc_ctrl.
- rsp_clean  in  32  from rwc_ctrl.

Behaviour:
- Reset (async, resetn=0):
  - state IDLE;
  - busy, done, gen_enable, err_timeout all 0;
  - response, cha_data, cha_addr all 0;
  - idx, timeout counter and gap counter all 0.
- A reset mid-batch aborts it immediately: gen_enable drops asynchronously and no done pulse is issued.
- States: IDLE, ISSUE, WAIT_AVAIL, CAPTURE, GAP, FINISH.
- IDLE:
  - start=1 -> ISSUE.
  - Loads cha_data=SEED and cha_addr=base_addr, clears response/err_timeout/idx, sets busy.
- ISSUE:
  - gen_enable<=1 and timeout counter cleared; -> WAIT_AVAIL next cycle.
  - cha_data/cha_addr are stable from ISSUE through CAPTURE.
- WAIT_AVAIL:
  - gen_enable held 1; the timeout counter increments each cycle.
  - If available=1: -> CAPTURE (takes priority over a timeout in the same cycle).
  - Else if counter==TIMEOUT_CYC-1: err_timeout<=1, response[idx]<=0, gen_enable<=0, -> GAP.
- CAPTURE:
  - gen_enable<=0.
  - response[idx] <= XOR-reduce(rsp_write ^ rsp_clean), with rsp_* sampled in this cycle.
  - -> GAP.
- GAP:
  - Waits GAP_CYC cycles, i.e. GAP_CYC clock edges in GAP.
  - Then if idx==NUM_CHAL-1 -> FINISH.
  - Else: idx+1; cha_addr <= (cha_addr+ADDR_STEP) mod 1024; cha_data <= LFSR step; -> ISSUE.
- LFSR step: next = {d[30:0], d[31]^d[21]^d[1]^d[0]}.
- FINISH: done=1 for exactly one cycle, busy<=0, -> IDLE. response is held until the next accepted start.
- start during busy: ignored, with no effect on state or outputs.
- available while gen_enable=0: ignored.
- Minimum latency per challenge (available high on the first WAIT_AVAIL cycle): 1 (ISSUE) + 1 (WAIT_AVAIL) + 1 (CAPTURE) + GAP_CYC cycles.

Optional Feature:
- Macro: RWC_MAJORITY_VOTE_EN.
- Defined:
  - each challenge is issued 3 times with identical cha_data/cha_addr (ISSUE..GAP repeated);
  - a 2-bit vote counter accumulates per-trial bits;
  - response[idx] = 1 iff at least 2 trial bits are 1;
  - a timed-out trial counts as a 0 vote and sets err_timeout;
  - the LFSR and address advance only after the third trial.
- Undefined: one trial per challenge as described above. Vote logic is absent.

Test Plan:
- Basic batch:
  - setup: NUM_CHAL=4, base_addr=10'd5, ADDR_STEP=1; model answers available=1 two cycles after gen_enable rises.
  - check: cha_addr sequence 5,6,7,8; cha_data sequence 32'h2c77_d388 then successive LFSR steps; one done pulse; busy low afterwards.
- Response bit:
  - stimulus: model returns rsp_write=32'h0000_0001, rsp_clean=0 for challenge 0, and rsp_write=rsp_clean=32'hFFFF_0000 for challenge 1.
  - check: response[0]=1, response[1]=0.
- Timeout:
  - setup: TIMEOUT_CYC=8; model never asserts available for challenge 2 of 4.
  - check: gen_enable drops after 8 WAIT_AVAIL cycles; response[2]=0; err_timeout=1 after done; challenge 3 still issued.
- Start while busy:
  - stimulus: pulse start mid-batch.
  - check: no restart; cha_addr continues its sequence; exactly one done.
  - stimulus: then a new start after done.
  - check: err_timeout and response are cleared.
- Reset mid-batch:
  - stimulus: resetn=0 during WAIT_AVAIL.
  - check: gen_enable=0, busy=0, response=0 immediately; no done pulse; a following start runs a clean batch from SEED.
- With RWC_MAJORITY_VOTE_EN:
  - stimulus: model returns trial bits 1,0,1.
  - check: response[idx]=1; cha_addr unchanged across all 3 trials.
  - stimulus: trial bits 0,0,1.
  - check: response[idx]=0.

Source files
------------

// File: rtl/rwc_chal_sched.sv
// rwc_chal_sched: runs a batch of NUM_CHAL challenges through rwc_ctrl and
// assembles a multi-bit PUF response, one bit per challenge.
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   start, base_addr   batch request and first challenge address (IDLE only)
//   busy, done         batch in progress / one-cycle completion pulse
//   response           bit i = response of challenge i, upper bits read 0
//   err_timeout        sticky: some challenge never saw available
//   gen_enable, cha_data, cha_addr   request side towards rwc_ctrl
//   available, rsp_write, rsp_clean  result side from rwc_ctrl
//
// Build option: define RWC_MAJORITY_VOTE_EN to issue every challenge three
// times and resolve its response bit by 2-of-3 majority.
module rwc_chal_sched #(
  parameter int unsigned NUM_CHAL    = 32,
  parameter logic [31:0] SEED        = 32'h2c77_d388,
  parameter logic [9:0]  ADDR_STEP   = 10'd1,
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter int unsigned GAP_CYC     = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [9:0]  base_addr,
  output logic        busy,
  output logic        done,
  output logic [31:0] response,
  output logic        err_timeout,
  output logic        gen_enable,
  output logic [31:0] cha_data,
  output logic [31:0] cha_addr,
  input  logic        available,
  input  logic [31:0] rsp_write,
  input  logic [31:0] rsp_clean
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam int IW = 5;

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_AVAIL, CAPTURE, GAP, FINISH
  } state_e;

  state_e          state_q, state_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            gen_q, gen_d;
  logic            err_q, err_d;
  logic [31:0]     resp_q, resp_d;
  logic [31:0]     data_q, data_d;
  logic [9:0]      addr_q, addr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [GW-1:0]   gap_q, gap_d;
`ifdef RWC_MAJORITY_VOTE_EN
  logic [1:0]      trial_q, trial_d;
  logic [1:0]      vote_q, vote_d;
  logic [1:0]      vote_sum;
`endif

  // rec: a trial finished this cycle with result rec_bit.
  // adv: gap expired and the current challenge is complete.
  logic rec, rec_bit, adv;

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    gen_d   = gen_q;
    err_d   = err_q;
    resp_d  = resp_q;
    data_d  = data_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    gap_d   = gap_q;
    rec     = 1'b0;
    rec_bit = 1'b0;
    adv     = 1'b0;
`ifdef RWC_MAJORITY_VOTE_EN
    trial_d  = trial_q;
    vote_d   = vote_q;
    vote_sum = vote_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          busy_d  = 1'b1;
          data_d  = SEED;
          addr_d  = base_addr;
          resp_d  = '0;
          err_d   = 1'b0;
          idx_d   = '0;
`ifdef RWC_MAJORITY_VOTE_EN
          trial_d = '0;
          vote_d  = '0;
`endif
        end
      end
      ISSUE: begin
        gen_d   = 1'b1;
        tmo_d   = '0;
        state_d = WAIT_AVAIL;
      end
      WAIT_AVAIL: begin
        tmo_d = tmo_q + TW'(1);
        // A late answer on the final cycle still wins over the timeout.
        if (available) begin
          state_d = CAPTURE;
        end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          gen_d   = 1'b0;
          rec     = 1'b1;
          gap_d   = '0;
          state_d = GAP;
        end
      end
      CAPTURE: begin
        gen_d   = 1'b0;
        rec     = 1'b1;
        rec_bit = ^(rsp_write ^ rsp_clean);
        gap_d   = '0;
        state_d = GAP;
      end
      GAP: begin
        if (gap_q == GW'(GAP_CYC - 1)) begin
`ifdef RWC_MAJORITY_VOTE_EN
          // Re-issue the same challenge until the third trial is done.
          if (trial_q != 2'd2) begin
            trial_d = trial_q + 2'd1;
            state_d = ISSUE;
          end else begin
            trial_d = '0;
            adv     = 1'b1;
          end
`else
          adv = 1'b1;
`endif
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      FINISH: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (rec) begin
`ifdef RWC_MAJORITY_VOTE_EN
      // Sum never exceeds 3, so bit 1 set means at least two 1 votes.
      vote_sum = vote_q + {1'b0, rec_bit};
      if (trial_q == 2'd2) begin
        resp_d[idx_q] = vote_sum[1];
        vote_d        = '0;
      end else begin
        vote_d = vote_sum;
      end
`else
      resp_d[idx_q] = rec_bit;
`endif
    end

    if (adv) begin
      if (idx_q == IW'(NUM_CHAL - 1)) begin
        state_d = FINISH;
        done_d  = 1'b1;
      end else begin
        idx_d   = idx_q + IW'(1);
        addr_d  = addr_q + ADDR_STEP;  // 10-bit add wraps modulo 1024
        data_d  = {data_q[30:0], data_q[31] ^ data_q[21] ^ data_q[1] ^ data_q[0]};
        state_d = ISSUE;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gen_q   <= 1'b0;
      err_q   <= 1'b0;
      resp_q  <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
      gap_q   <= '0;
`ifdef RWC_MAJORITY_VOTE_EN
      trial_q <= '0;
      vote_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      gen_q   <= gen_d;
      err_q   <= err_d;
      resp_q  <= resp_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      gap_q   <= gap_d;
`ifdef RWC_MAJORITY_VOTE_EN
      trial_q <= trial_d;
      vote_q  <= vote_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign gen_enable  = gen_q;
  assign err_timeout = err_q;
  assign response    = resp_q;
  assign cha_data    = data_q;
  assign cha_addr    = {22'd0, addr_q};

endmodule
